// File: rtl/serial_sub_n_if.sv
// Bundle of the serial subtractor's start/operand/result signals.
// The master side issues operands and start; the slave side is the subtractor.
interface serial_sub_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_sub_n.sv
// Serial subtractor: computes a - b - bin over WIDTH/BPC clock cycles,
// BPC bits per cycle, LSB slice first, borrow carried between slices in a
// register. Visible results only change on the final slice; partial
// difference bits accumulate in an internal shift register.
module serial_sub_n #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic          clk,
  input  logic          rst,
  serial_sub_n_if.slave bus
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;      // captured minuend, shifted right each slice
  logic [WIDTH-1:0] b_sh;      // captured subtrahend, shifted right each slice
  logic [WIDTH-1:0] acc;       // partial difference, filled from the top
  logic             borrow;    // borrow carried into the next slice
  logic [CW-1:0]    cnt;       // slice index within the RUN phase
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  // Per-slice ripple: c[0] is the carried borrow, c[BPC] leaves the slice.
  logic [BPC:0]         c;
  logic [BPC-1:0]       d;
  logic [WIDTH+BPC-1:0] acc_cat;
  logic [WIDTH-1:0]     acc_next;

  assign c[0] = borrow;

  for (genvar gi = 0; gi < BPC; gi++) begin : g_bit
    assign d[gi]     = a_sh[gi] ^ b_sh[gi] ^ c[gi];
    assign c[gi + 1] = (~a_sh[gi] & b_sh[gi]) | (~a_sh[gi] & c[gi]) | (b_sh[gi] & c[gi]);
  end

  // New slice bits enter at the top so the LSB slice ends up at bit 0
  // after N shifts; the concatenation keeps this valid even when BPC == WIDTH.
  assign acc_cat  = {d, acc};
  assign acc_next = acc_cat[WIDTH+BPC-1:BPC];

  // FSM, operand capture, slice processing and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            borrow <= bus.bin;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> BPC;
          b_sh   <= b_sh >> BPC;
          borrow <= c[BPC];
          acc    <= acc_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            diff_q <= acc_next;
            bout_q <= c[BPC];
            // Signed overflow: borrow into the MSB differs from borrow out.
            ovf_q  <= c[BPC-1] ^ c[BPC];
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub_n.sv
// Self-checking bench for serial_sub_n: directed cases, randomized operands
// against an arithmetic reference, reset abort, ignored starts, and an
// exhaustive 4-bit sweep for BPC = 1, 2, 4 with start held high.
module tb_serial_sub_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit go4     = 1'b0;
  int fin4    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void ref_sub(input int w, input longint a, input longint b, input longint bi,
                                  output logic [63:0] d, output logic [63:0] bo,
                                  output logic [63:0] ov);
    longint full = a - b - bi;
    longint half = longint'(1) << (w - 1);
    longint sa   = (a >= half) ? a - 2 * half : a;
    longint sb   = (b >= half) ? b - 2 * half : b;
    longint sr   = sa - sb - bi;
    d  = 64'(full) & ((64'd1 << w) - 64'd1);
    bo = (full < 0) ? 64'd1 : 64'd0;
    ov = (sr < -half || sr > half - 1) ? 64'd1 : 64'd0;
  endfunction

  // 8-bit DUTs: if8a is BPC=1, if8b is BPC=4.
  serial_sub_n_if #(.WIDTH(8)) if8a ();
  serial_sub_n_if #(.WIDTH(8)) if8b ();
  serial_sub_n #(.WIDTH(8), .BPC(1)) dut8a (.clk(clk), .rst(rst), .bus(if8a.slave));
  serial_sub_n #(.WIDTH(8), .BPC(4)) dut8b (.clk(clk), .rst(rst), .bus(if8b.slave));

  task automatic drive8(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                        input logic bi);
    if (sel == 0) begin
      if8a.start = st; if8a.a = a; if8a.b = b; if8a.bin = bi;
    end else begin
      if8b.start = st; if8b.a = a; if8b.b = b; if8b.bin = bi;
    end
  endtask

  // {busy, done, bout, ovf, diff}
  function automatic logic [11:0] obs8(input int sel);
    if (sel == 0) return {if8a.busy, if8a.done, if8a.bout, if8a.ovf, if8a.diff};
    return {if8b.busy, if8b.done, if8b.bout, if8b.ovf, if8b.diff};
  endfunction

  // One operation: one-cycle start, scrambled operands afterwards, bounded wait.
  task automatic op8(input int sel, input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic bi);
    int n = (sel == 0) ? 8 : 2;
    int lat = -1;
    int busy_n = 0;
    bit stable = 1'b1;
    logic [11:0] o;
    logic [11:0] o0;
    logic [63:0] ed, eb, eo;
    @(negedge clk);
    drive8(sel, 1'b1, a, b, bi);
    @(posedge clk);
    @(negedge clk);
    drive8(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    o0 = obs8(sel);
    o  = o0;
    for (int k = 0; k < 40; k++) begin
      o = obs8(sel);
      if (o[11]) busy_n++;
      if (o[10]) begin
        lat = k + 1;
        break;
      end
      if (o[9:0] != o0[9:0]) stable = 1'b0;
      drive8(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      @(negedge clk);
    end
    ref_sub(8, a, b, bi, ed, eb, eo);
    check({tag, " latency"}, 64'(lat), 64'(n + 1));
    check({tag, " busy cycles"}, 64'(busy_n), 64'(n));
    check({tag, " diff"}, 64'(o[7:0]), ed);
    check({tag, " bout"}, 64'(o[9]), eb);
    check({tag, " ovf"}, 64'(o[8]), eo);
    check({tag, " held during run"}, 64'(stable), 64'd1);
    $display("[TB] %s a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d ovf=%0d lat=%0d",
             tag, a, b, bi, o[7:0], o[9], o[8], lat);
  endtask

  // Exhaustive 4-bit sweeps, one per BPC, run in parallel once go4 is set.
  for (genvar gi = 0; gi < 3; gi++) begin : g4
    localparam int BP = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    localparam int N  = 4 / BP;
    serial_sub_n_if #(.WIDTH(4)) bus4 ();
    serial_sub_n #(.WIDTH(4), .BPC(BP)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    initial begin : sweep
      int q[$];
      int idx;
      int got;
      int cyc;
      int last_done;
      int op;
      bit prev_busy;
      logic [63:0] ed, eb, eo;
      idx = 0; got = 0; cyc = 0; last_done = -1; prev_busy = 1'b0;
      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
      wait (go4);
      @(negedge clk);
      bus4.a = 4'd0; bus4.b = 4'd0; bus4.bin = 1'b0; bus4.start = 1'b1;
      while (got < 512 && cyc < 512 * (N + 2) + 100) begin
        @(negedge clk);
        cyc++;
        if (bus4.busy && !prev_busy) begin
          q.push_back(idx);
          idx++;
          if (idx < 512) begin
            bus4.a = 4'(idx); bus4.b = 4'(idx >> 4); bus4.bin = 1'(idx >> 8);
          end else begin
            bus4.start = 1'b0;
          end
        end
        prev_busy = bus4.busy;
        if (bus4.done) begin
          check($sformatf("w4 bpc%0d pending ops", BP), 64'(q.size()), 64'd1);
          if (q.size() > 0) begin
            op = q.pop_front();
            ref_sub(4, op & 15, (op >> 4) & 15, op >> 8, ed, eb, eo);
            check($sformatf("w4 bpc%0d diff op%0d", BP, op), 64'(bus4.diff), ed);
            check($sformatf("w4 bpc%0d bout op%0d", BP, op), 64'(bus4.bout), eb);
            check($sformatf("w4 bpc%0d ovf op%0d", BP, op), 64'(bus4.ovf), eo);
          end
          if (last_done >= 0)
            check($sformatf("w4 bpc%0d done spacing", BP), 64'(cyc - last_done), 64'(N + 2));
          last_done = cyc;
          got++;
        end
      end
      check($sformatf("w4 bpc%0d results seen", BP), 64'(got), 64'd512);
      $display("[TB] sweep WIDTH=4 BPC=%0d: %0d results checked", BP, got);
      fin4++;
    end
  end

  initial begin
    logic [11:0] o;
    int dn;
    int lat;
    int late_busy;

    rst = 1'b1;
    drive8(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive8(1, 1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    check("reset outputs 8a", 64'(obs8(0)), 64'd0);
    check("reset outputs 8b", 64'(obs8(1)), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed basics.
    op8(0, "basic 05-03", 8'h05, 8'h03, 1'b0);
    op8(0, "00-01", 8'h00, 8'h01, 1'b0);
    op8(0, "80-01", 8'h80, 8'h01, 1'b0);
    op8(0, "00-00-1", 8'h00, 8'h00, 1'b1);

    // Starts during RUN and DONE must be ignored.
    @(negedge clk);
    drive8(0, 1'b1, 8'h10, 8'h01, 1'b0);
    @(posedge clk);
    @(negedge clk);
    dn = 0; lat = -1; late_busy = 0;
    for (int k = 0; k < 30; k++) begin
      o = obs8(0);
      if (o[10]) begin
        dn++;
        if (lat < 0) lat = k + 1;
      end
      if (lat > 0 && o[11]) late_busy++;
      drive8(0, (k == 2) || (lat == k + 1), (k >= 2) ? 8'hFF : 8'h10,
             (k >= 2) ? 8'hFF : 8'h01, 1'b0);
      @(negedge clk);
    end
    drive8(0, 1'b0, 8'h00, 8'h00, 1'b0);
    o = obs8(0);
    check("ignore-start done pulses", 64'(dn), 64'd1);
    check("ignore-start latency", 64'(lat), 64'd9);
    check("ignore-start no restart", 64'(late_busy), 64'd0);
    check("ignore-start diff", 64'(o[7:0]), 64'h0F);
    $display("[TB] ignore-start a=10 b=01 -> diff=%02h dones=%0d lat=%0d", o[7:0], dn, lat);

    // Reset mid-RUN aborts without done.
    @(negedge clk);
    drive8(0, 1'b1, 8'h55, 8'h11, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive8(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("pre-reset busy", 64'(obs8(0) >> 11), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async reset outputs", 64'(obs8(0)), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (15) begin
      @(negedge clk);
      if (obs8(0) >> 10 != 0) dn++;
    end
    check("abort no done/busy", 64'(dn), 64'd0);
    $display("[TB] reset abort: done/busy cycles after reset=%0d", dn);
    op8(0, "after reset 09-04", 8'h09, 8'h04, 1'b0);

    // Four bits per cycle.
    op8(1, "bpc4 3C-4D-1", 8'h3C, 8'h4D, 1'b1);

    // Randomized operands on both 8-bit configurations.
    for (int i = 0; i < 24; i++)
      op8(i % 2, $sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));

    // 4-bit exhaustive sweeps.
    go4 = 1'b1;
    for (int t = 0; t < 25000 && fin4 < 3; t++) @(negedge clk);
    check("sweeps finished", 64'(fin4), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub_n.md
SERIAL_SUB_N -- requirements
Module: serial_sub_n

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits; legal values are 2 to 64.
REQ-002 Parameter BPC, default 1, SHALL set the number of bits processed per cycle; legal values are 1 to WIDTH, and BPC SHALL divide WIDTH exactly.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  request to begin a subtraction, sampled on the rising edge of clk.
REQ-007 a  in  WIDTH  minuend.
REQ-008 b  in  WIDTH  subtrahend.
REQ-009 bin  in  1  borrow-in.
REQ-010 busy  out  1  high while an operation is in progress.
REQ-011 done  out  1  single-cycle completion pulse.
REQ-012 diff  out  WIDTH  result of a - b - bin.
REQ-013 bout  out  1  borrow-out of the MSB.
REQ-014 ovf  out  1  two's-complement signed overflow.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 FSM transitions SHALL be:
- IDLE to RUN on start=1.
- RUN to DONE after the last slice.
- DONE to IDLE unconditionally.
REQ-017 On an accepted start, the block SHALL capture a, b and bin into internal registers and clear the slice counter.
REQ-018 In RUN, each clock edge SHALL process one BPC-bit slice, LSB slice first, by rippling the full-subtract equations bit by bit:
- d = x^y^c
- borrow = (~x&y) | (~x&c) | (y&c)
The borrow chain SHALL start from the captured bin.
REQ-019 The borrow SHALL be carried between slices in a register.
REQ-020 A RUN phase SHALL take exactly N = WIDTH/BPC edges.
REQ-021 Latency: for start sampled at edge E0, slices are processed at edges E1..EN. diff, bout and ovf SHALL update at EN. done=1 and busy=0 SHALL hold for the cycle following EN (the DONE state).
REQ-022 busy SHALL be high from E0 through EN, i.e. in RUN only.
REQ-023 ovf SHALL equal (borrow into MSB) XOR (borrow out of MSB).
REQ-024 Results SHALL be computed modulo 2^WIDTH, with bout=1 exactly when a < b + bin (unsigned).
REQ-025 diff, bout and ovf SHALL hold their values from EN until the next completion. They SHALL NOT change during RUN; partial results are kept in internal registers only.
REQ-026 start SHALL be ignored in RUN and in DONE; operands SHALL be taken only in IDLE.
REQ-027 Changes on a, b and bin after E0 SHALL NOT affect the result in progress.
REQ-028 Back-to-back operation: start held high SHALL begin a new operation in the IDLE cycle after DONE, giving a throughput of one result per N+2 cycles.

Reset
REQ-029 rst=1 SHALL immediately force the following, regardless of clk: FSM to IDLE; busy, done, diff, bout and ovf to 0; internal operand, borrow and counter registers to 0.
REQ-030 Reset asserted mid-RUN SHALL abort the operation with no done pulse. The first start sampled after rst deasserts SHALL begin a fresh operation.

Verification
REQ-031 WIDTH=8, BPC=1: a=0x05, b=0x03, bin=0, start for 1 cycle -> done exactly 9 edges after the start edge; diff=0x02, bout=0, ovf=0; busy high for 8 cycles.
REQ-032 WIDTH=8, BPC=1, three directed cases:
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
- a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0.
REQ-033 WIDTH=8, BPC=1: start a=0x10, b=0x01; pulse start again with a=0xFF, b=0xFF at cycle 3 of RUN and during DONE -> single done pulse, diff=0x0F; second start ignored; diff stable until the next completion.
REQ-034 WIDTH=8, BPC=1: assert rst at cycle 4 of RUN -> all outputs 0 immediately; no done pulse; next start a=0x09, b=0x04 -> diff=0x05 after normal latency.
REQ-035 WIDTH=8, BPC=4: a=0x3C, b=0x4D, bin=1 -> done 3 edges after start; diff=0xEE, bout=1, ovf=0.
REQ-036 WIDTH=4, BPC in {1, 2, 4}: exhaustive sweep of all a, b and bin with start held high -> every result matches a golden a-b-bin model for diff, bout and ovf, and done spacing is N+2 cycles.
